cache_fill_arb: RTL and testbench

Arbiter and line-fill sequencer that shares the single cache-to-SPIFI slave read port between two requesters: demand miss refills (port D) and a sequential prefetcher (port P). It sits between cache_mem_top's fill logic and cache_ahb_ctrl_out, and drives the existing sel/addr/rdata/ready slave handshake. Each granted request becomes a full-line burst. Bursts are critical-word-first: they start at the requested word and wrap within the line.

---
 rtl/cache_fill_arb_pkg.sv | 31 +++
 rtl/cache_fill_arb_addr_gen.sv | 67 ++++++
 rtl/cache_fill_arb.sv | 168 ++++++++++++++++
 tb/tb_cache_fill_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types for the cache line-fill arbiter.
//   fill_state_t : fill sequencer states (IDLE, BURST, GAP)
//   fill_owner_t : which requester currently owns the slave read port
//   line_words() : words per line for a given log2 line size
// Optional build macro used by cache_fill_arb: CACHE_FILL_ARB_PREEMPT_EN
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } fill_state_t;

    typedef enum logic {
        OWN_DEM = 1'b0,
        OWN_PF  = 1'b1
    } fill_owner_t;

    localparam int DEFAULT_NUM_WORD = 5;

    // Number of 32-bit words in a line of 2**num_word words.
    function automatic int line_words(input int num_word);
        return 1 << num_word;
    endfunction

    localparam int LINE_WORDS = line_words(DEFAULT_NUM_WORD);

endpackage

// File: rtl/cache_fill_arb_addr_gen.sv
// -----------------------------------------------------------------------------
// cache_fill_addr_gen
// Burst address generator for critical-word-first line fills. Holds the
// captured base word address and a word counter; produces the wrapped slave
// address and flags the final word of the line.
// Ports:
//   clk, srst   : clock, synchronous active-high reset
//   load        : capture load_addr as new base, clear the counter
//   load_addr   : critical word address of the new burst
//   advance     : one word of the burst completed
//   active      : burst in progress; address output is zero otherwise
//   slave_addr  : {base upper field, (base low field + count) wrapped}
//   last_word   : current count addresses the final word of the line
// -----------------------------------------------------------------------------
module cache_fill_addr_gen
    import cache_pkg::*;
#(
    parameter int NUM_WORD = 5,
    parameter int ADDR_W   = 30
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              advance,
    input  logic              active,
    output logic [ADDR_W-1:0] slave_addr,
    output logic              last_word
);

    // Counter is one bit wider than the word index so the compare below is
    // against the full count, not just the wrapped index.
    localparam logic [NUM_WORD:0] LAST_CNT = (NUM_WORD + 1)'(line_words(NUM_WORD) - 1);

    logic [ADDR_W-1:0]   base_reg;
    logic [NUM_WORD:0]   cnt_reg;
    logic [NUM_WORD-1:0] low_sum;
    logic [ADDR_W-1:0]   addr_raw;

    always_ff @(posedge clk) begin
        if (srst) begin
            base_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            base_reg <= load_addr;
            cnt_reg  <= '0;
        end else if (advance) begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    // Truncation to NUM_WORD bits gives the wrap within the line for free.
    assign low_sum = base_reg[NUM_WORD-1:0] + cnt_reg[NUM_WORD-1:0];

    // Low field wraps, upper field passes straight through from the base.
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_bit
        if (gi < NUM_WORD) begin : g_low
            assign addr_raw[gi] = low_sum[gi];
        end else begin : g_high
            assign addr_raw[gi] = base_reg[gi];
        end
    end

    assign slave_addr = active ? addr_raw : '0;
    assign last_word  = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/cache_fill_arb.sv
// -----------------------------------------------------------------------------
// cache_fill_arb
// Shares the single cache-to-SPIFI slave read port between demand refills
// (port D) and the sequential prefetcher (port P). Each grant becomes a
// full-line, critical-word-first burst that wraps within the line, followed
// by one idle GAP cycle. Demand wins simultaneous requests.
// Ports:
//   i_hclk, i_hreset           : clock, synchronous active-high reset
//   i_dem_req/i_dem_addr       : demand request (level) and critical word
//   o_dem_ack/valid/last       : demand accept pulse, data strobe, final word
//   i_pf_req/i_pf_addr         : prefetch request (level) and start word
//   o_pf_ack/valid/last        : prefetch accept pulse, data strobe, final word
//   o_pf_abort                 : prefetch burst abandoned (preempt build only)
//   o_rdata                    : registered returned word, shared by D and P
//   o_slave_sel/o_slave_addr   : slave read request and word address
//   i_slave_rdata/i_slave_ready: slave data and word-complete strobe
//   o_busy, o_owner            : not idle; current owner (0 = D, 1 = P)
// Build option: define CACHE_FILL_ARB_PREEMPT_EN to let a demand abort an
// in-progress prefetch burst; otherwise o_pf_abort is tied low.
// -----------------------------------------------------------------------------
module cache_fill_arb
    import cache_pkg::*;
#(
    parameter int NUM_WORD = 5,
    parameter int ADDR_W   = 30
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_dem_req,
    input  logic [ADDR_W-1:0] i_dem_addr,
    output logic              o_dem_ack,
    output logic              o_dem_valid,
    output logic              o_dem_last,
    input  logic              i_pf_req,
    input  logic [ADDR_W-1:0] i_pf_addr,
    output logic              o_pf_ack,
    output logic              o_pf_valid,
    output logic              o_pf_last,
    output logic              o_pf_abort,
    output logic [31:0]       o_rdata,
    output logic              o_slave_sel,
    output logic [ADDR_W-1:0] o_slave_addr,
    input  logic [31:0]       i_slave_rdata,
    input  logic              i_slave_ready,
    output logic              o_busy,
    output logic              o_owner
);

    fill_state_t       state_reg, state_next;
    fill_owner_t       owner_reg, owner_next;
    logic              dem_ack_reg, pf_ack_reg;
    logic              dem_valid_reg, dem_last_reg;
    logic              pf_valid_reg, pf_last_reg;
    logic [31:0]       rdata_reg;

    logic              in_burst;
    logic              word_done;
    logic              last_word;
    logic              grant_dem, grant_pf;
    logic              preempt;
    logic [ADDR_W-1:0] load_addr;

    assign in_burst  = (state_reg == BURST);
    // Ready outside a burst is ignored.
    assign word_done = in_burst && i_slave_ready;
    assign grant_dem = (state_reg == IDLE) && i_dem_req;
    assign grant_pf  = (state_reg == IDLE) && !i_dem_req && i_pf_req;
    assign load_addr = grant_dem ? i_dem_addr : i_pf_addr;

`ifdef CACHE_FILL_ARB_PREEMPT_EN
    // A completing word is always delivered; the abort waits for a cycle
    // with no completion.
    assign preempt = in_burst && (owner_reg == OWN_PF) && i_dem_req && !word_done;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (grant_dem) begin
                    state_next = BURST;
                    owner_next = OWN_DEM;
                end else if (grant_pf) begin
                    state_next = BURST;
                    owner_next = OWN_PF;
                end
            end
            BURST: begin
                if ((word_done && last_word) || preempt) begin
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_DEM;
            dem_ack_reg   <= 1'b0;
            pf_ack_reg    <= 1'b0;
            dem_valid_reg <= 1'b0;
            dem_last_reg  <= 1'b0;
            pf_valid_reg  <= 1'b0;
            pf_last_reg   <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            dem_ack_reg   <= grant_dem;
            pf_ack_reg    <= grant_pf;
            dem_valid_reg <= word_done && (owner_reg == OWN_DEM);
            dem_last_reg  <= word_done && last_word && (owner_reg == OWN_DEM);
            pf_valid_reg  <= word_done && (owner_reg == OWN_PF);
            pf_last_reg   <= word_done && last_word && (owner_reg == OWN_PF);
            if (word_done) begin
                rdata_reg <= i_slave_rdata;
            end
        end
    end

`ifdef CACHE_FILL_ARB_PREEMPT_EN
    logic pf_abort_reg;

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            pf_abort_reg <= 1'b0;
        end else begin
            pf_abort_reg <= preempt;
        end
    end

    assign o_pf_abort = pf_abort_reg;
`else
    assign o_pf_abort = 1'b0;
`endif

    cache_fill_addr_gen #(
        .NUM_WORD (NUM_WORD),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk        (i_hclk),
        .srst       (i_hreset),
        .load       (grant_dem || grant_pf),
        .load_addr  (load_addr),
        .advance    (word_done),
        .active     (in_burst),
        .slave_addr (o_slave_addr),
        .last_word  (last_word)
    );

    assign o_dem_ack   = dem_ack_reg;
    assign o_dem_valid = dem_valid_reg;
    assign o_dem_last  = dem_last_reg;
    assign o_pf_ack    = pf_ack_reg;
    assign o_pf_valid  = pf_valid_reg;
    assign o_pf_last   = pf_last_reg;
    assign o_rdata     = rdata_reg;
    assign o_slave_sel = in_burst;
    assign o_busy      = (state_reg != IDLE);
    assign o_owner     = owner_reg;

endmodule

// File: tb/tb_cache_fill_arb.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_arb
// Self-checking bench for cache_fill_arb with NUM_WORD = 2 (4-word lines).
// A transaction-level reference model tracks the current line fill (owner,
// base address, words delivered) and predicts every output each cycle; a
// vector table and hand-written sequences cover the named corner cases.
// Honours CACHE_FILL_ARB_PREEMPT_EN for the abort expectations.
// -----------------------------------------------------------------------------
module tb_cache_fill_arb;

    localparam int NW = 2;
    localparam int AW = 30;
    localparam int L  = 1 << NW;
`ifdef CACHE_FILL_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          hreset;
    logic          dem_req, pf_req, ready;
    logic [AW-1:0] dem_addr, pf_addr;
    logic [31:0]   srdata;
    logic          o_dem_ack, o_dem_valid, o_dem_last;
    logic          o_pf_ack, o_pf_valid, o_pf_last, o_pf_abort;
    logic [31:0]   o_rdata;
    logic          o_slave_sel;
    logic [AW-1:0] o_slave_addr;
    logic          o_busy, o_owner;

    always #5 clk = ~clk;

    cache_fill_arb #(
        .NUM_WORD (NW),
        .ADDR_W   (AW)
    ) dut (
        .i_hclk        (clk),
        .i_hreset      (hreset),
        .i_dem_req     (dem_req),
        .i_dem_addr    (dem_addr),
        .o_dem_ack     (o_dem_ack),
        .o_dem_valid   (o_dem_valid),
        .o_dem_last    (o_dem_last),
        .i_pf_req      (pf_req),
        .i_pf_addr     (pf_addr),
        .o_pf_ack      (o_pf_ack),
        .o_pf_valid    (o_pf_valid),
        .o_pf_last     (o_pf_last),
        .o_pf_abort    (o_pf_abort),
        .o_rdata       (o_rdata),
        .o_slave_sel   (o_slave_sel),
        .o_slave_addr  (o_slave_addr),
        .i_slave_rdata (srdata),
        .i_slave_ready (ready),
        .o_busy        (o_busy),
        .o_owner       (o_owner)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one line fill at a time.
    bit          m_active;   // a burst is in progress
    bit          m_gap;      // the mandatory idle cycle after a burst
    int          m_own;      // 0 = demand, 1 = prefetch
    int          m_base;     // critical word address of the burst
    int          m_k;        // words already delivered in this burst
    logic [31:0] m_rdata;

    // Observation counters for the hand-written sequences.
    int cnt_dv, cnt_dl, cnt_pv, cnt_pl, cnt_ab;
    int last_dem_base, last_pf_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Word address of the k-th word of a wrapped burst starting at base.
    function automatic int line_addr(input int base, input int k);
        return (base / L) * L + ((base + k) % L);
    endfunction

    task automatic clear_counts();
        cnt_dv = 0; cnt_dl = 0; cnt_pv = 0; cnt_pl = 0; cnt_ab = 0;
    endtask

    // Advance one clock, sample #1 later, and check every output against
    // the model's prediction for the inputs present at that edge.
    task automatic step();
        bit qual, exp_abort, idle_now, exp_dack, exp_pack, ended, exp_last;
        @(posedge clk);
        #1;
        if (hreset) begin
            chk("rst_dem_ack", o_dem_ack, 0);
            chk("rst_dem_valid", o_dem_valid, 0);
            chk("rst_dem_last", o_dem_last, 0);
            chk("rst_pf_ack", o_pf_ack, 0);
            chk("rst_pf_valid", o_pf_valid, 0);
            chk("rst_pf_last", o_pf_last, 0);
            chk("rst_pf_abort", o_pf_abort, 0);
            chk("rst_rdata", o_rdata, 0);
            chk("rst_sel", o_slave_sel, 0);
            chk("rst_addr", o_slave_addr, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_owner", o_owner, 0);
            m_active = 0; m_gap = 0; m_own = 0; m_base = 0; m_k = 0; m_rdata = 0;
        end else begin
            qual      = m_active && ready;
            exp_last  = qual && (m_k == L - 1);
            exp_abort = PRE && m_active && (m_own == 1) && dem_req && !qual;
            idle_now  = !m_active && !m_gap;
            exp_dack  = idle_now && dem_req;
            exp_pack  = idle_now && !dem_req && pf_req;
            if (qual) m_rdata = srdata;

            chk("dem_ack", o_dem_ack, exp_dack);
            chk("pf_ack", o_pf_ack, exp_pack);
            chk("dem_valid", o_dem_valid, qual && m_own == 0);
            chk("pf_valid", o_pf_valid, qual && m_own == 1);
            chk("dem_last", o_dem_last, exp_last && m_own == 0);
            chk("pf_last", o_pf_last, exp_last && m_own == 1);
            chk("pf_abort", o_pf_abort, exp_abort);
            chk("rdata", o_rdata, m_rdata);

            ended = exp_last || exp_abort;
            if (qual) m_k++;
            if (ended) m_active = 0;
            m_gap = ended;
            if (exp_dack || exp_pack) begin
                m_active = 1;
                m_k      = 0;
                m_own    = exp_pack ? 1 : 0;
                m_base   = exp_dack ? int'(dem_addr) : int'(pf_addr);
            end

            chk("slave_sel", o_slave_sel, m_active);
            chk("slave_addr", o_slave_addr, m_active ? line_addr(m_base, m_k) : 0);
            chk("busy", o_busy, m_active || m_gap);
            chk("owner", o_owner, m_own);
        end
        if (o_dem_valid) cnt_dv++;
        if (o_dem_last)  cnt_dl++;
        if (o_pf_valid)  cnt_pv++;
        if (o_pf_last)   cnt_pl++;
        if (o_pf_abort)  cnt_ab++;
        if (o_dem_ack)   last_dem_base = int'(o_slave_addr);
        if (o_pf_ack)    last_pf_base  = int'(o_slave_addr);
        $display("[TB] t=%0t dreq=%0b preq=%0b rdy=%0b sel=%0b addr=0x%0h dv=%0b pv=%0b rdata=0x%0h",
                 $time, dem_req, pf_req, ready, o_slave_sel, o_slave_addr,
                 o_dem_valid, o_pf_valid, o_rdata);
    endtask

    // Run with ready every cycle until idle with no pending request.
    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            ready  = 1'b1;
            srdata = $urandom;
            step();
            if (o_dem_ack) dem_req = 1'b0;
            if (o_pf_ack)  pf_req  = 1'b0;
            if (!o_busy && !dem_req && !pf_req) done = 1;
        end
        chk({name, "_drained"}, done, 1);
    endtask

    typedef struct {
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          rdy;
        logic [31:0]   rd;
        logic          e_ack;
        logic          e_dv;
        logic          e_last;
        logic          e_sel;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_rdata;
        logic          e_busy;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nq, nv;

        // Demand at word 6 of a 4-word line: addresses 6,7,4,5, last on 5.
        tbl[0] = '{1'b1, 30'h6, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 30'h6, 32'h0,  1'b1};
        tbl[1] = '{1'b0, 30'h6, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b1, 30'h7, 32'hA0, 1'b1};
        tbl[2] = '{1'b0, 30'h6, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b1, 30'h4, 32'hA1, 1'b1};
        tbl[3] = '{1'b0, 30'h6, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 30'h5, 32'hA2, 1'b1};
        tbl[4] = '{1'b0, 30'h6, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 32'hA3, 1'b1};
        tbl[5] = '{1'b0, 30'h6, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'hA3, 1'b0};

        hreset = 1'b1; dem_req = 1'b0; pf_req = 1'b0; ready = 1'b0;
        dem_addr = '0; pf_addr = '0; srdata = '0;
        m_active = 0; m_gap = 0; m_own = 0; m_base = 0; m_k = 0; m_rdata = 0;
        last_dem_base = -1; last_pf_base = -1;
        clear_counts();
        step();
        step();
        hreset = 1'b0;

        // Table-driven basic demand line.
        for (int i = 0; i < 6; i++) begin
            dem_req  = tbl[i].dreq;
            dem_addr = tbl[i].daddr;
            ready    = tbl[i].rdy;
            srdata   = tbl[i].rd;
            step();
            chk($sformatf("tbl%0d_ack", i), o_dem_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_valid", i), o_dem_valid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_last", i), o_dem_last, tbl[i].e_last);
            chk($sformatf("tbl%0d_sel", i), o_slave_sel, tbl[i].e_sel);
            chk($sformatf("tbl%0d_addr", i), o_slave_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_rdata", i), o_rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
        end

        // Simultaneous requests: demand first, prefetch after line + GAP.
        dem_req = 1'b1; dem_addr = 30'h10; pf_req = 1'b1; pf_addr = 30'h20; ready = 1'b0;
        step();
        chk("sim_dem_first", o_dem_ack, 1);
        chk("sim_pf_waits", o_pf_ack, 0);
        dem_req = 1'b0;
        drain("sim");
        chk("sim_dem_base", last_dem_base, 32'h10);
        chk("sim_pf_base", last_pf_base, 32'h20);

        // Slow slave with spurious ready while not selected.
        clear_counts();
        ready = 1'b1; srdata = 32'hEE;
        for (int i = 0; i < 3; i++) step();
        dem_req = 1'b1; dem_addr = 30'h8; ready = 1'b0;
        step();
        dem_req = 1'b0;
        nq = 0; nv = 0;
        for (int c = 0; c < 24; c++) begin
            ready  = (c % 3 == 2) || !o_slave_sel;
            srdata = (ready && o_slave_sel) ? 32'hA0 + nq : 32'hEE;
            if (ready && o_slave_sel) nq++;
            step();
            if (o_dem_valid) begin
                chk($sformatf("slow_rdata%0d", nv), o_rdata, 32'hA0 + nv);
                nv++;
            end
        end
        chk("slow_valid_count", nv, L);
        chk("slow_last_count", cnt_dl, 1);

        // Reset after 2 of 4 words, then a clean new demand.
        dem_req = 1'b1; dem_addr = 30'h24; ready = 1'b0;
        step();
        dem_req = 1'b0; ready = 1'b1;
        step();
        step();
        hreset = 1'b1;
        step();
        hreset = 1'b0; ready = 1'b0;
        clear_counts();
        step();
        chk("rst_idle_after", o_busy, 0);
        dem_req = 1'b1; dem_addr = 30'h30;
        drain("post_rst");
        chk("post_rst_valids", cnt_dv, L);
        chk("post_rst_lasts", cnt_dl, 1);
        chk("post_rst_base", last_dem_base, 32'h30);

        // Demand arrives during a prefetch burst.
        clear_counts();
        pf_req = 1'b1; pf_addr = 30'h40; ready = 1'b0;
        step();
        pf_req = 1'b0; ready = 1'b1; srdata = 32'h55;
        step();
        dem_req = 1'b1; dem_addr = 30'h80; ready = 1'b0;
        step();
        chk("pre_abort_now", o_pf_abort, PRE);
        drain("pre");
        chk("pre_pf_valids", cnt_pv, PRE ? 1 : L);
        chk("pre_pf_lasts", cnt_pl, PRE ? 0 : 1);
        chk("pre_aborts", cnt_ab, PRE ? 1 : 0);
        chk("pre_dem_valids", cnt_dv, L);
        chk("pre_dem_base", last_dem_base, 32'h80);

        // Randomised traffic against the model.
        for (int c = 0; c < 800; c++) begin
            ready  = ($urandom_range(0, 2) != 0);
            srdata = $urandom;
            step();
            if (o_dem_ack) dem_req = 1'b0;
            else if (!dem_req && $urandom_range(0, 7) == 0) begin
                dem_req  = 1'b1;
                dem_addr = 30'($urandom);
            end
            if (o_pf_ack) pf_req = 1'b0;
            else if (!pf_req && $urandom_range(0, 4) == 0) begin
                pf_req  = 1'b1;
                pf_addr = 30'($urandom);
            end
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
